requant_sched: RTL and testbench
================================

Name: requant_sched

Overview:
- Round-robin burst scheduler that shares one requantization stage among NUM_REQ accumulator sources (conv PE channels).
- Requantization: 20-bit signed fixed-point accumulator with FRAC_W fractional bits, rounded half-up and saturated to signed OUT_W bits.
- Results leave through a registered valid/ready output tagged with source id, feeding the activation writeback path.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- IN_W, 20, accumulator width, signed two's complement
- OUT_W, 8, output width, signed two's complement
- FRAC_W, 8, fractional bits of accumulator (1..IN_W-OUT_W)
- BURST_LEN, 16, max beats per grant before forced rotation (>=1)
- ID_W (localparam), $clog2(NUM_REQ), width of id fields

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester beat valid
- req_last  in  NUM_REQ  per-requester end-of-row marker
- req_data  in  NUM_REQ*IN_W  accumulators; requester i at [i*IN_W +: IN_W]
- req_ready  out  NUM_REQ  per-requester beat accepted
- out_valid  out  1  result valid
- out_ready  in  1  downstream ready
- out_data  out  OUT_W  requantized result
- out_id  out  ID_W  source requester index
- out_last  out  1  final beat of the current burst
- busy  out  1  high while state is BURST or out_valid is high

Behaviour:
- Reset (async, immediate): state=IDLE, rr_ptr=0, owner=0, beat_cnt=0, out_valid=0, out_data=0, out_id=0, out_last=0, req_ready=0.
- Reset mid-burst discards the in-flight beat and the burst; no output after release until a new grant.
- slot = !out_valid | out_ready (output register free or draining this cycle).
- IDLE:
  - scan req_valid starting at rr_ptr, wrapping;
  - first set bit becomes owner, beat_cnt=0, go to BURST;
  - no beat accepted in the arbitration cycle (1-cycle bubble).
- BURST:
  - req_ready[owner] = slot; all other req_ready = 0;
  - beat accepted when req_valid[owner] & req_ready[owner]; beat_cnt increments per accepted beat;
  - owner dropping req_valid mid-burst stalls; grant is held (no timeout).
- Burst end: an accepted beat with req_last[owner]=1 or beat_cnt==BURST_LEN-1. On that edge: state=IDLE, rr_ptr=(owner+1) mod NUM_REQ, and the beat's out_last=1.
- Arithmetic:
  - q = (acc >>> FRAC_W) + acc[FRAC_W-1], computed at IN_W-FRAC_W+1 bits to avoid wrap;
  - saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Output stage:
  - accepted beat appears on out_data/out_id/out_last with out_valid=1 the next cycle (latency 1);
  - out_valid & !out_ready: all out_* held stable;
  - out_valid falls only after a handshake with no new beat;
  - throughput within a burst is 1 beat/cycle when out_ready=1.

Optional Feature:
- Macro REQUANT_SAT_CNT_EN.
- Defined: adds input sat_clr (1) and output sat_cnt (16).
  - sat_cnt increments on every accepted beat whose value was clipped, sticking at 0xFFFF; reset value 0.
  - sat_clr=1 synchronously zeroes sat_cnt and takes priority over a same-cycle increment.
- Undefined: neither port exists and no counter logic is generated.

Test Plan:
- Rounding, req0 single beat with last, out_ready=1:
  - 0x00180 -> out_data 0x02;
  - 0x0017F -> 0x01;
  - 0xFFE80 -> 0xFF;
  - 0xFFE7F -> 0xFE;
  - each result 2 cycles after req_valid rises (arbitration bubble + latency 1).
- Saturation:
  - 0x08000 -> 0x7F;
  - 0x7FFFF -> 0x7F (carry overflow case);
  - 0xF7F00 -> 0x80;
  - 0x80000 -> 0x80;
  - 0x07F7F -> 0x7F (in range).
- Round-robin, BURST_LEN=4, all 4 requesters always valid, no last: out_id sequence 0,0,0,0,1,1,1,1,2,...,3,0; out_last on every 4th beat.
- req_last on the 2nd beat of requester 2 while 1 and 3 are also valid: burst ends after 2 beats with out_last=1; next grant goes to 3, not 1.
- out_ready held 0 for 5 cycles mid-burst: out_data/out_id stable, req_ready[owner]=0 after one buffered beat, no beat lost or duplicated; count of outputs == count of inputs.
- rst_n pulsed low for 1 cycle mid-burst: out_valid=0 and busy=0 immediately; next grant starts at requester 0 after release.

Source files
------------

// File: rtl/requant_sched.sv
// requant_sched: round-robin burst scheduler sharing one requantizer (round half-up, saturate) among NUM_REQ sources.
// Optional saturation counter (sat_clr/sat_cnt) is built when REQUANT_SAT_CNT_EN is defined.
module requant_sched #(
  parameter int NUM_REQ = 4,
  parameter int IN_W = 20,
  parameter int OUT_W = 8,
  parameter int FRAC_W = 8,
  parameter int BURST_LEN = 16,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
`ifdef REQUANT_SAT_CNT_EN
  input  logic                    sat_clr,
  output logic [15:0]             sat_cnt,
`endif
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0]      req_last,
  input  logic [NUM_REQ*IN_W-1:0] req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_data,
  output logic [ID_W-1:0]         out_id,
  output logic                    out_last,
  output logic                    busy
);
  localparam int CW = $clog2(BURST_LEN + 1);
  localparam int QW = IN_W - FRAC_W + 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t state, state_nx;
  logic [ID_W-1:0] rr_ptr, owner, pick;
  logic [ID_W:0] idx;
  logic found;
  logic [CW-1:0] beat_cnt;
  logic slot, accept, burst_end, clipped;
  logic [QW-1:0] acc_hi, q;
  logic [OUT_W-1:0] q_sat;

  assign slot = !out_valid | out_ready;
  assign accept = (state == BURST) && req_valid[owner] && slot;
  assign burst_end = accept && (req_last[owner] || beat_cnt == CW'(BURST_LEN - 1));
  assign busy = (state == BURST) | out_valid;

  // acc_hi holds the integer part plus the half-LSB rounding bit
  assign acc_hi = req_data[owner*IN_W + FRAC_W - 1 +: QW];
  assign q = {acc_hi[QW-1], acc_hi[QW-1:1]} + QW'(acc_hi[0]);
  assign clipped = q[QW-1:OUT_W-1] != {(QW-OUT_W+1){q[QW-1]}};
  assign q_sat = clipped ? {q[QW-1], {(OUT_W-1){!q[QW-1]}}} : q[OUT_W-1:0];

  always_comb begin
    found = 1'b0;
    pick = '0;
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
      if (!found && req_valid[idx[ID_W-1:0]]) begin
        found = 1'b1;
        pick = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    state_nx = (state == IDLE) ? (found ? BURST : IDLE) : (burst_end ? IDLE : BURST);
    req_ready = '0;
    if (state == BURST) req_ready[owner] = slot;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rr_ptr <= '0;
      owner <= '0;
      beat_cnt <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_id <= '0;
      out_last <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && found) begin
        owner <= pick;
        beat_cnt <= '0;
      end else if (accept) beat_cnt <= beat_cnt + CW'(1);
      if (burst_end) rr_ptr <= (owner == ID_W'(NUM_REQ - 1)) ? '0 : owner + ID_W'(1);
      if (accept) begin
        out_valid <= 1'b1;
        out_data <= q_sat;
        out_id <= owner;
        out_last <= burst_end;
      end else if (out_ready) out_valid <= 1'b0;
    end
  end

`ifdef REQUANT_SAT_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_cnt <= '0;
    else if (sat_clr) sat_cnt <= '0;
    else if (accept && clipped && sat_cnt != 16'hFFFF) sat_cnt <= sat_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_requant_sched.sv
// tb_requant_sched: directed checks of rounding, saturation, round-robin bursts, early last, backpressure and reset.
module tb_requant_sched;
  logic clk = 0, rst_n = 0, out_ready = 1;
  logic [3:0] req_valid = '0, req_last = '0, req_ready;
  logic [79:0] req_data = '0;
  logic out_valid, out_last, busy;
  logic [7:0] out_data;
  logic [1:0] out_id;
  int n_chk = 0, n_fail = 0;

  requant_sched #(.NUM_REQ(4), .IN_W(20), .OUT_W(8), .FRAC_W(8), .BURST_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_id(out_id), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 0;
    tick;
    rst_n = 1;
  endtask

  task automatic set_data(input int i, input logic [19:0] v);
    req_data[i*20 +: 20] = v;
  endtask

  task automatic rq(input string tag, input logic [19:0] v, input logic [7:0] e);
    set_data(0, v);
    req_valid = 4'b0001;
    req_last = 4'b0001;
    tick;
    chk({tag, "_busy"}, busy, 1);
    tick;
    chk({tag, "_valid"}, out_valid, 1);
    chk(tag, out_data, e);
    chk({tag, "_last"}, out_last, 1);
    req_valid = '0;
    req_last = '0;
    tick;
    chk({tag, "_drop"}, out_valid, 0);
  endtask

  initial begin
    int got_n, sent, rcv;
    logic acc_now, prev_stall;
    logic [9:0] prev;
    tick;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_id", out_id, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    rst_n = 1;
    tick;
    rq("rnd_180", 20'h00180, 8'h02);
    rq("rnd_17f", 20'h0017F, 8'h01);
    rq("rnd_e80", 20'hFFE80, 8'hFF);
    rq("rnd_e7f", 20'hFFE7F, 8'hFE);
    rq("sat_8000", 20'h08000, 8'h7F);
    rq("sat_7ffff", 20'h7FFFF, 8'h7F);
    rq("sat_f7f00", 20'hF7F00, 8'h80);
    rq("sat_80000", 20'h80000, 8'h80);
    rq("sat_07f7f", 20'h07F7F, 8'h7F);

    // round-robin with all requesters streaming
    do_reset;
    for (int i = 0; i < 4; i++) set_data(i, 20'((i + 1) * 256));
    req_valid = 4'hF;
    got_n = 0;
    for (int c = 0; c < 100 && got_n < 17; c++) begin
      tick;
      if (out_valid) begin
        chk("rr_id", out_id, (got_n / 4) % 4);
        chk("rr_last", out_last, got_n % 4 == 3);
        chk("rr_data", out_data, (got_n / 4) % 4 + 1);
        got_n++;
      end
    end
    chk("rr_count", got_n, 17);
    req_valid = '0;

    // early last from requester 2 hands the grant to 3
    do_reset;
    req_valid = 4'b0010;
    req_last = 4'b0010;
    tick;
    tick;
    chk("el_id1", out_id, 1);
    req_valid = '0;
    req_last = '0;
    tick;
    req_valid = 4'b1110;
    tick;
    chk("el_rdy2", req_ready, 4'b0100);
    tick;
    chk("el_b0_id", out_id, 2);
    chk("el_b0_last", out_last, 0);
    req_last = 4'b0100;
    tick;
    chk("el_b1_id", out_id, 2);
    chk("el_b1_last", out_last, 1);
    req_last = '0;
    tick;
    chk("el_bubble", out_valid, 0);
    chk("el_rdy3", req_ready, 4'b1000);
    tick;
    chk("el_next_valid", out_valid, 1);
    chk("el_next_id", out_id, 3);
    chk("el_next_data", out_data, 4);
    req_valid = '0;

    // backpressure mid-burst, every beat numbered
    do_reset;
    sent = 0;
    rcv = 0;
    prev = '0;
    prev_stall = 0;
    set_data(0, 20'(256));
    req_valid = 4'b0001;
    for (int c = 0; c < 80 && rcv < 10; c++) begin
      out_ready = !(c >= 6 && c < 11);
      #1;
      if (out_valid && !out_ready) begin
        chk("stall_rdy", req_ready[0], 0);
        if (prev_stall) chk("stall_hold", {out_id, out_data}, prev);
      end
      if (out_valid && out_ready) begin
        chk("stall_seq", out_data, rcv + 1);
        rcv++;
      end
      prev = {out_id, out_data};
      prev_stall = out_valid && !out_ready;
      acc_now = req_valid[0] & req_ready[0];
      tick;
      if (acc_now) begin
        sent++;
        set_data(0, 20'((sent + 1) * 256));
        if (sent == 10) req_valid = '0;
      end
    end
    chk("stall_rcv", rcv, 10);
    chk("stall_sent", sent, 10);
    out_ready = 1;

    // reset pulse in the middle of requester 1's burst
    do_reset;
    for (int i = 0; i < 4; i++) set_data(i, 20'((i + 1) * 256));
    req_valid = 4'hF;
    repeat (7) tick;
    chk("rp_pre_id", out_id, 1);
    rst_n = 0;
    #1;
    chk("rp_valid", out_valid, 0);
    chk("rp_busy", busy, 0);
    chk("rp_ready", req_ready, 0);
    tick;
    rst_n = 1;
    chk("rp_rel_valid", out_valid, 0);
    tick;
    chk("rp_grant0", req_ready, 4'b0001);
    tick;
    chk("rp_out_valid", out_valid, 1);
    chk("rp_out_id", out_id, 0);
    req_valid = '0;
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
